// File: rtl/serial_tx.sv
// ---------------------------------------------------------------------------
// serial_tx
//
// Parallel-to-serial frame transmitter. A WIDTH-bit word is accepted through
// a valid/ready handshake and sent on an idle-high line as one start bit (0),
// WIDTH data bits LSB-first and one stop bit (1). Each line bit is held for
// CLKS_PER_BIT clocks.
//
// Parameters:
//   WIDTH         data bits per frame (>= 1)
//   CLKS_PER_BIT  clock cycles each line bit is held (>= 1)
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous, active-high reset
//   data_in  in   word to send, sampled only on the accept edge
//   valid    in   upstream offers data_in
//   ready    out  block can accept a word (idle and not in reset)
//   tx       out  serial line, registered, idle high
//   busy     out  a frame is in progress
//   done     out  registered one-cycle pulse when a stop bit completes
// ---------------------------------------------------------------------------
module serial_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid,
    output logic             ready,
    output logic             tx,
    output logic             busy,
    output logic             done
);

    // Counter widths never drop below one bit so CLKS_PER_BIT=1 and WIDTH=1
    // still get a real (constant-zero) counter instead of a zero-width vector.
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [WIDTH-1:0] SHIFT_ZERO = WIDTH'(0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    // Registered state
    state_t            state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [IDX_W-1:0]  idx_r;
    logic [WIDTH-1:0]  shift_r;
    logic              tx_r;
    logic              done_r;

    // Next-state values
    state_t            state_s;
    logic [CNT_W-1:0]  cnt_s;
    logic [IDX_W-1:0]  idx_s;
    logic [WIDTH-1:0]  shift_s;
    logic              tx_s;
    logic              done_s;

    // Helpers
    logic              bit_end_s;
    logic              accept_s;
    logic [WIDTH-1:0]  shift_dn_s;

    // Handshake and status outputs; ready is masked by rst so nothing can be
    // accepted on an edge where reset is also asserted.
    assign ready = (state_r == ST_IDLE) && !rst;
    assign busy  = (state_r != ST_IDLE);
    assign tx    = tx_r;
    assign done  = done_r;

    assign accept_s   = valid && ready;
    assign bit_end_s  = (cnt_r == CNT_LAST);
    assign shift_dn_s = shift_r >> 1;

    // Next-state, datapath and line-level decode for the frame sequencer.
    // tx_s is the value the line takes after the coming edge, so the first
    // bit of every line period is produced on the edge that starts it.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        idx_s   = idx_r;
        shift_s = shift_r;
        tx_s    = tx_r;
        done_s  = 1'b0;

        case (state_r)
            ST_IDLE: begin
                tx_s  = 1'b1;
                cnt_s = CNT_ZERO;
                idx_s = IDX_ZERO;
                if (accept_s) begin
                    // Line falls on the accept edge itself: zero latency.
                    shift_s = data_in;
                    tx_s    = 1'b0;
                    state_s = ST_START;
                end else begin
                    shift_s = shift_r;
                end
            end

            ST_START: begin
                tx_s = 1'b0;
                if (bit_end_s) begin
                    cnt_s   = CNT_ZERO;
                    idx_s   = IDX_ZERO;
                    tx_s    = shift_r[0];
                    state_s = ST_DATA;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end

            ST_DATA: begin
                tx_s = shift_r[0];
                if (bit_end_s) begin
                    cnt_s   = CNT_ZERO;
                    shift_s = shift_dn_s;
                    if (idx_r == IDX_LAST) begin
                        idx_s   = IDX_ZERO;
                        tx_s    = 1'b1;
                        state_s = ST_STOP;
                    end else begin
                        // Next data bit is the new LSB after the shift.
                        idx_s = idx_r + IDX_ONE;
                        tx_s  = shift_dn_s[0];
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end

            ST_STOP: begin
                tx_s = 1'b1;
                if (bit_end_s) begin
                    cnt_s   = CNT_ZERO;
                    done_s  = 1'b1;
                    state_s = ST_IDLE;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end

            default: begin
                // Unreachable encodings recover to a quiet idle line.
                state_s = ST_IDLE;
                cnt_s   = CNT_ZERO;
                idx_s   = IDX_ZERO;
                shift_s = SHIFT_ZERO;
                tx_s    = 1'b1;
                done_s  = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset; reset aborts any
    // frame in flight without producing a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            idx_r   <= IDX_ZERO;
            shift_r <= SHIFT_ZERO;
            tx_r    <= 1'b1;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            idx_r   <= idx_s;
            shift_r <= shift_s;
            tx_r    <= tx_s;
            done_r  <= done_s;
        end
    end

endmodule

// File: tb/tb_serial_tx.sv
// ---------------------------------------------------------------------------
// tb_serial_tx
//
// Scoreboard bench for serial_tx. Two instances: inst0 (WIDTH=8,
// CLKS_PER_BIT=4) and inst1 (WIDTH=8, CLKS_PER_BIT=1). Stimulus pushes the
// hand-written expected line pattern {stop, data[7:0], start} for each word
// it offers; a negedge monitor detects accepts, pops the expectation and
// checks the line every cycle of the frame plus the done pulse.
// ---------------------------------------------------------------------------
module tb_serial_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0, valid0, ready0, tx0, busy0, done0;
    logic [7:0] data0;
    logic       rst1, valid1, ready1, tx1, busy1, done1;
    logic [7:0] data1;

    serial_tx #(.WIDTH(8), .CLKS_PER_BIT(4)) dut (
        .clk(clk), .rst(rst0), .data_in(data0), .valid(valid0),
        .ready(ready0), .tx(tx0), .busy(busy0), .done(done0)
    );

    serial_tx #(.WIDTH(8), .CLKS_PER_BIT(1)) dut1 (
        .clk(clk), .rst(rst1), .data_in(data1), .valid(valid1),
        .ready(ready1), .tx(tx1), .busy(busy1), .done(done1)
    );

    typedef struct {
        logic [9:0] frame;   // bit j = line value during bit period j
        bit         aborts;  // frame is expected to be cut by reset
        int         gap;     // required cycles since previous accept (0 = any)
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int checks = 0;
    int errors = 0;

    bit   active   [2];
    bit   rst_pend [2];
    int   n        [2];
    int   last_acc [2];
    exp_t cur      [2];
    int   cyc = 0;

    task automatic chk(input string name, input int k,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d got %0h expected %0h at %0t",
                     name, k, act, exp, $time);
        end
    endtask

    task automatic mon_step(input int k, input int cpb, input logic tx,
                            input logic busy, input logic ready,
                            input logic done, input logic valid,
                            input logic rst);
        int   total;
        int   j;
        exp_t e;
        total = cpb * 10;
        if (rst_pend[k]) begin
            chk("abort_tx", k, tx, 1);
            chk("abort_busy", k, busy, 0);
            chk("abort_done", k, done, 0);
            rst_pend[k] = 1'b0;
        end
        if (active[k]) begin
            if (rst) begin
                chk("abort_expected", k, cur[k].aborts, 1);
                active[k]   = 1'b0;
                rst_pend[k] = 1'b1;
            end else if (n[k] < total) begin
                j = n[k] / cpb;
                chk("line_bit", k, tx, cur[k].frame[j]);
                chk("busy_in_frame", k, busy, 1);
                chk("ready_in_frame", k, ready, 0);
                chk("done_early", k, done, 0);
                n[k]++;
            end else begin
                chk("done_pulse", k, done, 1);
                chk("end_tx", k, tx, 1);
                chk("end_busy", k, busy, 0);
                chk("end_ready", k, ready, 1);
                chk("completion_expected", k, cur[k].aborts, 0);
                active[k] = 1'b0;
            end
        end else if (!rst) begin
            chk("idle_done", k, done, 0);
            chk("idle_tx", k, tx, 1);
        end
        if (valid && ready && !rst) begin
            if (active[k]) begin
                chk("accept_while_busy", k, ready, 0);
            end else if ((k == 0 ? q0.size() : q1.size()) == 0) begin
                chk("unexpected_accept", k, 0, 1);
            end else begin
                e = (k == 0) ? q0.pop_front() : q1.pop_front();
                if (e.gap > 0) chk("accept_gap", k, cyc - last_acc[k], e.gap);
                last_acc[k] = cyc;
                cur[k]      = e;
                active[k]   = 1'b1;
                n[k]        = 0;
            end
        end
    endtask

    // Monitor: samples both instances away from the active edge.
    always @(negedge clk) begin
        cyc++;
        mon_step(0, 4, tx0, busy0, ready0, done0, valid0, rst0);
        mon_step(1, 1, tx1, busy1, ready1, done1, valid1, rst1);
    end

    task automatic wait_cycles(input int c);
        repeat (c) @(posedge clk);
        #1;
    endtask

    task automatic push(input int k, input logic [9:0] f, input bit ab,
                        input int gap);
        exp_t e;
        e.frame  = f;
        e.aborts = ab;
        e.gap    = gap;
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic send(input int k, input logic [7:0] d, input logic [9:0] f,
                        input bit ab);
        push(k, f, ab, 0);
        if (k == 0) begin data0 = d; valid0 = 1'b1; end
        else        begin data1 = d; valid1 = 1'b1; end
        wait_cycles(1);
        if (k == 0) begin valid0 = 1'b0; data0 = ~d; end
        else        begin valid1 = 1'b0; data1 = ~d; end
    endtask

    initial begin
        rst0 = 1'b1; valid0 = 1'b1; data0 = 8'hA5;
        rst1 = 1'b1; valid1 = 1'b1; data1 = 8'h5A;

        // Reset held 3 cycles with valid high: nothing may start.
        repeat (3) begin
            wait_cycles(1);
            chk("rst_ready", 0, ready0, 0);
            chk("rst_tx", 0, tx0, 1);
            chk("rst_busy", 0, busy0, 0);
            chk("rst_done", 0, done0, 0);
            chk("rst_ready", 1, ready1, 0);
        end
        rst0 = 1'b0; valid0 = 1'b0;
        rst1 = 1'b0; valid1 = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 0, ready0, 1);
        chk("ready_after_rst", 1, ready1, 1);
        wait_cycles(1);

        // Single frame 8'hA5: 0,1,0,1,0,0,1,0,1,1.
        send(0, 8'hA5, 10'b1101001010, 1'b0);
        wait_cycles(45);

        // Back-to-back 8'h00 then 8'hFF with valid held high.
        push(0, 10'b1000000000, 1'b0, 0);
        push(0, 10'b1111111110, 1'b0, 41);
        data0 = 8'h00; valid0 = 1'b1;
        wait_cycles(1);
        data0 = 8'hFF;
        wait_cycles(41);
        valid0 = 1'b0; data0 = 8'h00;
        wait_cycles(45);

        // Busy ignore: 8'h3C on the line, mid-frame 8'hC3 offer is ignored.
        send(0, 8'h3C, 10'b1001111000, 1'b0);
        wait_cycles(10);
        data0 = 8'hC3; valid0 = 1'b1;
        wait_cycles(1);
        valid0 = 1'b0;
        wait_cycles(35);

        // Reset during data bit 3 (cycles 16..19) of 8'hF0.
        send(0, 8'hF0, 10'b1111100000, 1'b1);
        wait_cycles(17);
        rst0 = 1'b1;
        wait_cycles(1);
        rst0 = 1'b0;
        wait_cycles(5);
        send(0, 8'h81, 10'b1100000010, 1'b0);
        wait_cycles(45);

        // Minimum divider: 8'h5A -> 0,0,1,0,1,1,0,1,0,1 in 10 cycles.
        send(1, 8'h5A, 10'b1010110100, 1'b0);
        wait_cycles(15);

        chk("frames_pending", 0, q0.size() + int'(active[0]), 0);
        chk("frames_pending", 1, q1.size() + int'(active[1]), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_tx.md
# serial_tx

Parallel-to-serial frame transmitter for the sequential-design library. It accepts a WIDTH-bit word through a valid/ready handshake. It then drives it onto a single idle-high line as one start bit (0), WIDTH data bits LSB-first, and one stop bit (1), each held for CLKS_PER_BIT clocks. It is the sending end of the single-bit serial stream that flop- and shift-register-based receivers in the library sample.

## Interface

- WIDTH, 8, data bits per frame (≥1)
- CLKS_PER_BIT, 4, clock cycles each line bit is held (≥1)

- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- data_in  input  WIDTH  word to send; sampled only on the accept edge
- valid  input  1  upstream offers data_in
- ready  output  1  block can accept; = (state==IDLE) && !rst
- tx  output  1  serial line, registered, idle high
- busy  output  1  = (state != IDLE)
- done  output  1  registered one-cycle pulse when a frame's stop bit completes

## Operation

- Single clock `clk`. Reset `rst` is synchronous and active-high.
- Reset values after a rst edge: state=IDLE, tx=1, done=0, busy=0, bit counter=0, cycle counter=0, shift register=0. ready is 0 while rst is high and 1 in the cycle after rst falls.
- FSM: IDLE → START → DATA → STOP → IDLE.
  - IDLE: tx=1. On an edge with valid && ready, latch data_in into the shift register, clear the counters, and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx = shift register bit 0. After CLKS_PER_BIT cycles, shift right and increment the bit index. After bit WIDTH-1 completes, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE and pulse done.
- The cycle counter runs 0..CLKS_PER_BIT-1 and wraps. Its width is clog2(CLKS_PER_BIT) with a minimum of 1. The bit index width is clog2(WIDTH) with a minimum of 1.
- valid is ignored while busy. data_in changes during a frame do not affect the frame.
- Reset mid-frame aborts the frame. tx=1 and state=IDLE after the rst edge. No done pulse is produced.
- rst and valid high on the same edge: reset wins and nothing is accepted.

## Timing

- Let E0 be the accept edge. The line then follows this sequence:
  - From E0: tx=0 (start bit).
  - From E0+CLKS_PER_BIT·(1+i): tx=data bit i, for i = 0..WIDTH-1.
  - From E0+CLKS_PER_BIT·(WIDTH+1): tx=1 (stop bit).
  - At edge E0+CLKS_PER_BIT·(WIDTH+2): state=IDLE and done=1 for exactly one cycle.
- Frame length on the line is (WIDTH+2)·CLKS_PER_BIT cycles.
- The first idle cycle has ready=1. With valid held high, the next accept edge is E0+(WIDTH+2)·CLKS_PER_BIT+1. The minimum frame period is therefore (WIDTH+2)·CLKS_PER_BIT+1 cycles. The extra idle-high cycle is guaranteed and must stay at exactly one.
- Latency from accept edge to first line change (tx falling) is 0 cycles after the edge, because tx is registered on the accept edge.
- CLKS_PER_BIT=1 is legal: each bit lasts one cycle, with no special case in the counter.

## Test plan

- Reset values: hold rst for 3 cycles with valid=1 → tx=1, busy=0, done=0, ready=0 during reset, no frame starts. ready=1 in the first cycle after rst falls.
- Single frame: WIDTH=8, CLKS_PER_BIT=4, data_in=8'hA5. Sample tx mid-bit → 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop). Each bit lasts exactly 4 cycles. done pulses once, 40 cycles after accept.
- Back-to-back: valid held high with 8'h00, then 8'hFF → two frames separated by exactly one idle-high cycle. The accept edges are 41 cycles apart.
- Busy ignore: assert valid with 8'h3C at the accept edge. Mid-frame, change data_in to 8'hC3 and pulse valid → the line carries only 8'h3C, ready stays 0 until the frame ends, and exactly one done pulse occurs.
- Reset mid-frame: assert rst during data bit 3 of 8'hF0 → tx=1, busy=0 after that edge, no done pulse. A new accept of 8'h81 afterwards produces a clean full frame.
- Minimum divider: CLKS_PER_BIT=1, WIDTH=8, data 8'h5A → 10-cycle frame 0,0,1,0,1,1,0,1,0,1. done occurs 10 cycles after accept.
